// File: rtl/wb_sequencer.sv
// ---------------------------------------------------------------------------
// wb_sequencer
//
// Write-back / PC-enable sequencer for a single-issue core. ALU and
// PC-relative results retire in the cycle the instruction is presented.
// Loads park the sequencer in LOAD_WAIT until data memory acknowledges.
//
// Optional feature (compile-time macro WB_TIMEOUT_EN):
//   A load waiting TIMEOUT_CYCLES cycles without MemAck is abandoned. The
//   sequencer spends one cycle in ABORT and sets the sticky TimeoutErr flag.
//   Without the macro a load waits forever and TimeoutErr is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  LOAD_WAIT cycles allowed before abort (2..255)
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   InstValid      decoded instruction presented this cycle
//   RUWrIn         instruction writes its destination register
//   RUDataWrSrcIn  write-back source: 00 ALU, 01 load, 10 PC+off, 11 illegal
//   RdIn           destination register index
//   MemAck         data memory holds valid read data this cycle
//   Ready          sequencer accepts InstValid this cycle
//   MemReq         load outstanding to data memory
//   RUDataWrSrc    write-back mux select
//   RUWr           register-unit write enable
//   RdOut          register-unit write index
//   PCEn           PC may advance this cycle
//   TimeoutErr     sticky load-timeout flag
// ---------------------------------------------------------------------------
module wb_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       InstValid,
   input  logic       RUWrIn,
   input  logic [1:0] RUDataWrSrcIn,
   input  logic [4:0] RdIn,
   input  logic       MemAck,
   output logic       Ready,
   output logic       MemReq,
   output logic [1:0] RUDataWrSrc,
   output logic       RUWr,
   output logic [4:0] RdOut,
   output logic       PCEn,
   output logic       TimeoutErr
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
`ifdef WB_TIMEOUT_EN
   localparam logic [1:0] ST_ABORT     = 2'd2;
`endif

   localparam logic [1:0] SRC_ALU = 2'b00;
   localparam logic [1:0] SRC_MEM = 2'b01;
   localparam logic [1:0] SRC_PC  = 2'b10;

   // Elaboration-time guard on the timeout range.
   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range_bad
      $error("wb_sequencer: TIMEOUT_CYCLES must be in 2..255");
   end

   logic [1:0] state_q, state_d;
   logic [4:0] rd_q, rd_d;
   logic       wr_q, wr_d;

   logic       ready_s;
   logic       mem_req_s;
   logic [1:0] src_s;
   logic       ru_wr_s;
   logic [4:0] rd_out_s;
   logic       pc_en_s;

`ifdef WB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] cnt_q, cnt_d;
   logic [7:0] cnt_inc_s;
   logic       terr_q, terr_d;

   // cnt_inc_s is the number of ack-less wait cycles including this one.
   assign cnt_inc_s = cnt_q + 8'd1;
`endif

   // Next-state and same-cycle output decode.
   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      ready_s   = 1'b0;
      mem_req_s = 1'b0;
      src_s     = SRC_ALU;
      ru_wr_s   = 1'b0;
      rd_out_s  = 5'd0;
      pc_en_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_s = 1'b1;
            if (InstValid) begin
               case (RUDataWrSrcIn)
                  SRC_ALU, SRC_PC: begin
                     src_s    = RUDataWrSrcIn;
                     rd_out_s = RdIn;
                     ru_wr_s  = RUWrIn & (RdIn != 5'd0);
                     pc_en_s  = 1'b1;
                  end
                  SRC_MEM: begin
                     // Hold the PC and remember the destination until the data returns.
                     src_s    = SRC_MEM;
                     rd_out_s = RdIn;
                     rd_d     = RdIn;
                     wr_d     = RUWrIn;
                     state_d  = ST_LOAD_WAIT;
                  end
                  default: begin
                     // Illegal source: retire without writing anything.
                     pc_en_s = 1'b1;
                  end
               endcase
            end else begin
               pc_en_s = 1'b0;
            end
         end
         ST_LOAD_WAIT: begin
            mem_req_s = 1'b1;
            src_s     = SRC_MEM;
            rd_out_s  = rd_q;
            if (MemAck) begin
               // Ack takes priority over a timeout reached in the same cycle.
               ru_wr_s = wr_q & (rd_q != 5'd0);
               pc_en_s = 1'b1;
               state_d = ST_IDLE;
            end else begin
`ifdef WB_TIMEOUT_EN
               if (cnt_inc_s >= TIMEOUT_LIMIT) begin
                  state_d = ST_ABORT;
               end else begin
                  state_d = ST_LOAD_WAIT;
               end
`else
               state_d = ST_LOAD_WAIT;
`endif
            end
         end
`ifdef WB_TIMEOUT_EN
         ST_ABORT: begin
            // Drop the load, let the PC move past the faulting instruction.
            pc_en_s = 1'b1;
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef WB_TIMEOUT_EN
   // Wait counter and sticky timeout flag next values.
   always_comb begin
      cnt_d  = cnt_q;
      terr_d = terr_q;
      if ((state_q == ST_IDLE) && (state_d == ST_LOAD_WAIT)) begin
         cnt_d = 8'd0;
      end else if ((state_q == ST_LOAD_WAIT) && !MemAck) begin
         cnt_d = cnt_inc_s;
      end else begin
         cnt_d = cnt_q;
      end
      if (state_d == ST_ABORT) begin
         terr_d = 1'b1;
      end else begin
         terr_d = terr_q;
      end
   end

   // Counter and error flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 8'd0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         terr_q <= terr_d;
      end
   end

   assign TimeoutErr = rst_n & terr_q;
`else
   assign TimeoutErr = 1'b0;
`endif

   // FSM state and latched load destination.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rd_q    <= 5'd0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   // Outputs are forced low while reset is held, Ready included, even
   // though the state register already sits in IDLE.
   assign Ready       = rst_n & ready_s;
   assign MemReq      = rst_n & mem_req_s;
   assign RUDataWrSrc = src_s & {2{rst_n}};
   assign RUWr        = rst_n & ru_wr_s;
   assign RdOut       = rd_out_s & {5{rst_n}};
   assign PCEn        = rst_n & pc_en_s;

endmodule
